// File: rtl/sdram_port_arbiter_if.sv
// Toggle-handshake SDRAM port bundle.
// master: issues requests (drives a/q/we and the req toggles).
// slave : answers requests (drives the ack toggles and read data).
interface sdram_port_arbiter_if #(
  parameter int addrwidth = 16,
  parameter int datawidth = 16
);
  logic [addrwidth:1]   a;
  logic [datawidth-1:0] q;
  logic                 we;
  logic                 rd_req;
  logic                 rd_ack;
  logic                 wr_req;
  logic                 wr_ack;
  logic [datawidth-1:0] d;

  modport master (
    output a, q, we, rd_req, wr_req,
    input  rd_ack, wr_ack, d
  );

  modport slave (
    input  a, q, we, rd_req, wr_req,
    output rd_ack, wr_ack, d
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Two-client round-robin arbiter onto one toggle-handshake SDRAM controller port.
// One transaction in flight; acks and read data go back to the issuing client only.
// Optional feature macro: SDRAM_ARB_TIMEOUT_EN (WAIT timeout with sticky timeout output).
module sdram_port_arbiter #(
  parameter int addrwidth = 16,
  parameter int datawidth = 16,
  parameter int tmowidth  = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  sdram_port_arbiter_if.slave          c0,
  sdram_port_arbiter_if.slave          c1,
  sdram_port_arbiter_if.master         mem,
  output logic                         grant,
  output logic                         busy
`ifdef SDRAM_ARB_TIMEOUT_EN
  ,
  output logic                         timeout
`endif
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  logic [1:0]           state_q, state_d;
  logic                 grant_q, grant_d;
  logic                 busy_q, busy_d;
  logic                 op_wr_q, op_wr_d;
  logic                 mem_we_q, mem_we_d;
  logic                 mem_rd_req_q, mem_rd_req_d;
  logic                 mem_wr_req_q, mem_wr_req_d;
  logic                 c0_rd_ack_q, c0_rd_ack_d;
  logic                 c0_wr_ack_q, c0_wr_ack_d;
  logic                 c1_rd_ack_q, c1_rd_ack_d;
  logic                 c1_wr_ack_q, c1_wr_ack_d;
  logic [addrwidth:1]   mem_a_q, mem_a_d;
  logic [datawidth-1:0] mem_q_q, mem_q_d;
  logic [datawidth-1:0] c0_d_q, c0_d_d;
  logic [datawidth-1:0] c1_d_q, c1_d_d;
`ifdef SDRAM_ARB_TIMEOUT_EN
  logic [tmowidth-1:0]  tmo_q, tmo_d;
  logic                 timeout_q, timeout_d;
`else
  logic [tmowidth-1:0]  unused_tmo;
  assign unused_tmo = '0;
`endif

  // Client write flags are informational only; op selection uses the toggles.
  logic unused_we;
  assign unused_we = c0.we ^ c1.we;

  logic p0w, p0r, p1w, p1r, any_pend;
  logic sel, sel_w;
  logic fin;
  logic [datawidth-1:0] fin_data;

  assign p0w = c0.wr_req != c0_wr_ack_q;
  assign p0r = c0.rd_req != c0_rd_ack_q;
  assign p1w = c1.wr_req != c1_wr_ack_q;
  assign p1r = c1.rd_req != c1_rd_ack_q;
  assign any_pend = p0w | p0r | p1w | p1r;

  // Round-robin client choice (non-last-granted first), write beats read within a client.
  always_comb begin
    sel = grant_q;
    if (grant_q ? (p0w | p0r) : (p1w | p1r)) sel = ~grant_q;
    sel_w = sel ? p1w : p0w;
  end

  // Next-state logic for the IDLE -> ISSUE -> WAIT transaction sequence.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    busy_d       = busy_q;
    op_wr_d      = op_wr_q;
    mem_we_d     = mem_we_q;
    mem_rd_req_d = mem_rd_req_q;
    mem_wr_req_d = mem_wr_req_q;
    c0_rd_ack_d  = c0_rd_ack_q;
    c0_wr_ack_d  = c0_wr_ack_q;
    c1_rd_ack_d  = c1_rd_ack_q;
    c1_wr_ack_d  = c1_wr_ack_q;
    mem_a_d      = mem_a_q;
    mem_q_d      = mem_q_q;
    c0_d_d       = c0_d_q;
    c1_d_d       = c1_d_q;
`ifdef SDRAM_ARB_TIMEOUT_EN
    tmo_d        = tmo_q;
    timeout_d    = timeout_q;
`endif
    fin          = 1'b0;
    fin_data     = mem.d;

    case (state_q)
      ST_IDLE: begin
        if (any_pend) begin
          grant_d = sel;
          op_wr_d = sel_w;
          busy_d  = 1'b1;
          mem_a_d = sel ? c1.a : c0.a;
          mem_q_d = sel ? c1.q : c0.q;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        mem_we_d = op_wr_q;
        if (op_wr_q) mem_wr_req_d = ~mem.wr_ack;
        else         mem_rd_req_d = ~mem.rd_ack;
`ifdef SDRAM_ARB_TIMEOUT_EN
        tmo_d = '0;
`endif
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (op_wr_q ? (mem.wr_ack == mem_wr_req_q) : (mem.rd_ack == mem_rd_req_q)) begin
          fin = 1'b1;
        end
`ifdef SDRAM_ARB_TIMEOUT_EN
        else if (tmo_q == '1) begin
          // Give up: complete the client with all-ones data and retire the controller request.
          fin          = 1'b1;
          fin_data     = '1;
          mem_rd_req_d = mem.rd_ack;
          mem_wr_req_d = mem.wr_ack;
          timeout_d    = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    // Completion shared by normal ack and timeout: ack + data land on the same edge.
    if (fin) begin
      state_d  = ST_IDLE;
      mem_we_d = 1'b0;
      busy_d   = 1'b0;
      if (op_wr_q) begin
        if (grant_q) c1_wr_ack_d = ~c1_wr_ack_q;
        else         c0_wr_ack_d = ~c0_wr_ack_q;
      end else begin
        if (grant_q) begin
          c1_rd_ack_d = ~c1_rd_ack_q;
          c1_d_d      = fin_data;
        end else begin
          c0_rd_ack_d = ~c0_rd_ack_q;
          c0_d_d      = fin_data;
        end
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      busy_q       <= 1'b0;
      op_wr_q      <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_rd_req_q <= 1'b0;
      mem_wr_req_q <= 1'b0;
      c0_rd_ack_q  <= 1'b0;
      c0_wr_ack_q  <= 1'b0;
      c1_rd_ack_q  <= 1'b0;
      c1_wr_ack_q  <= 1'b0;
      mem_a_q      <= '0;
      mem_q_q      <= '0;
      c0_d_q       <= '0;
      c1_d_q       <= '0;
`ifdef SDRAM_ARB_TIMEOUT_EN
      tmo_q        <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      busy_q       <= busy_d;
      op_wr_q      <= op_wr_d;
      mem_we_q     <= mem_we_d;
      mem_rd_req_q <= mem_rd_req_d;
      mem_wr_req_q <= mem_wr_req_d;
      c0_rd_ack_q  <= c0_rd_ack_d;
      c0_wr_ack_q  <= c0_wr_ack_d;
      c1_rd_ack_q  <= c1_rd_ack_d;
      c1_wr_ack_q  <= c1_wr_ack_d;
      mem_a_q      <= mem_a_d;
      mem_q_q      <= mem_q_d;
      c0_d_q       <= c0_d_d;
      c1_d_q       <= c1_d_d;
`ifdef SDRAM_ARB_TIMEOUT_EN
      tmo_q        <= tmo_d;
      timeout_q    <= timeout_d;
`endif
    end
  end

  assign grant      = grant_q;
  assign busy       = busy_q;
  assign mem.a      = mem_a_q;
  assign mem.q      = mem_q_q;
  assign mem.we     = mem_we_q;
  assign mem.rd_req = mem_rd_req_q;
  assign mem.wr_req = mem_wr_req_q;
  assign c0.rd_ack  = c0_rd_ack_q;
  assign c0.wr_ack  = c0_wr_ack_q;
  assign c0.d       = c0_d_q;
  assign c1.rd_ack  = c1_rd_ack_q;
  assign c1.wr_ack  = c1_wr_ack_q;
  assign c1.d       = c1_d_q;
`ifdef SDRAM_ARB_TIMEOUT_EN
  assign timeout    = timeout_q;
`endif

endmodule
